// File: rtl/input_debounce_filter.sv
// Two-flop synchroniser plus a four-state debouncer: a level is accepted only
// after DEBOUNCE_CYCLES consecutive matching samples; aborted attempts are counted.
module input_debounce_filter #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5,
   parameter int GLITCH_W        = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                A_raw,
   output logic                A,
   output logic                A_rise,
   output logic                A_fall,
   output logic                settling,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t              state_q;
   logic                s1_q, s2_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                a_q, rise_q, fall_q, settling_q;
   logic [GLITCH_W-1:0] glitch_q;
   logic [GLITCH_W-1:0] glitch_d;

   function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb glitch_d = glitch_sat_inc(glitch_q);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         state_q    <= STABLE_LO;
         cnt_q      <= '0;
         a_q        <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         settling_q <= 1'b0;
         glitch_q   <= '0;
      end else begin
         s1_q   <= A_raw;
         s2_q   <= s1_q;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            STABLE_LO: begin
               cnt_q <= s2_q ? CNT_W'(1) : '0;
               settling_q <= s2_q;
               if (s2_q) state_q <= WAIT_HI;
            end
            WAIT_HI: begin
               if (!s2_q) begin
                  state_q    <= STABLE_LO;
                  glitch_q   <= glitch_d;
                  cnt_q      <= '0;
                  settling_q <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q    <= STABLE_HI;
                  a_q        <= 1'b1;
                  rise_q     <= 1'b1;
                  cnt_q      <= '0;
                  settling_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STABLE_HI: begin
               cnt_q <= !s2_q ? CNT_W'(1) : '0;
               settling_q <= !s2_q;
               if (!s2_q) state_q <= WAIT_LO;
            end
            WAIT_LO: begin
               if (s2_q) begin
                  state_q    <= STABLE_HI;
                  glitch_q   <= glitch_d;
                  cnt_q      <= '0;
                  settling_q <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q    <= STABLE_LO;
                  a_q        <= 1'b0;
                  fall_q     <= 1'b1;
                  cnt_q      <= '0;
                  settling_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Corrupted encodings fall back to a known-low level.
            default: begin
               state_q    <= STABLE_LO;
               a_q        <= 1'b0;
               cnt_q      <= '0;
               settling_q <= 1'b0;
            end
         endcase
      end
   end

   assign A          = a_q;
   assign A_rise     = rise_q;
   assign A_fall     = fall_q;
   assign settling   = settling_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debounce_filter.sv
// Directed bench for input_debounce_filter: acceptance latency, glitch
// rejection and saturation, async reset mid-settle, and random pulse widths.
module tb_input_debounce_filter;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       A_raw = 1'b0;
   logic       A, A_rise, A_fall, settling;
   logic [7:0] glitch_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int n_rise = 0;
   int n_fall = 0;

   input_debounce_filter #(.DEBOUNCE_CYCLES(16), .CNT_W(5), .GLITCH_W(8)) dut (
      .Clock(Clock), .Reset(Reset), .A_raw(A_raw), .A(A), .A_rise(A_rise),
      .A_fall(A_fall), .settling(settling), .glitch_cnt(glitch_cnt)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      #1;
      if (A_rise === 1'b1) n_rise++;
      if (A_fall === 1'b1) n_fall++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive_n(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         A_raw = v;
         @(negedge Clock);
      end
   endtask

   // Call just before the posedge that first samples the new level.
   task automatic expect_edge(input string tag, input logic rising);
      for (int j = 0; j < 20; j++) begin
         @(negedge Clock);
         chk({tag, "_A"}, A, rising ? (j >= 17) : (j < 17));
         chk({tag, "_rise"}, A_rise, rising && (j == 17));
         chk({tag, "_fall"}, A_fall, !rising && (j == 17));
         chk({tag, "_settling"}, settling, (j >= 2) && (j <= 16));
      end
   endtask

   initial begin
      int bad;
      int r0, f0;
      logic [31:0] hist;
      logic lvl, prev_a, v;
      int viol_w, viol_both, viol_int, rr, rf;

      // Reset and idle
      #2 Reset = 1'b0;
      #1;
      chk("rst_A", A, 0);
      chk("rst_rise", A_rise, 0);
      chk("rst_fall", A_fall, 0);
      chk("rst_settling", settling, 0);
      chk("rst_glitch", glitch_cnt, 0);
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clock);
         if (A !== 1'b0 || A_rise !== 1'b0 || A_fall !== 1'b0 ||
             settling !== 1'b0 || glitch_cnt !== 8'd0) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Clean rise: A at edge k+17
      A_raw = 1'b1;
      expect_edge("rise", 1'b1);
      chk("rise_glitch", glitch_cnt, 0);

      // Bounce then settle low: two rejected attempts, one fall
      f0 = n_fall;
      bad = 0;
      drive_n(1'b0, 3); drive_n(1'b1, 2); drive_n(1'b0, 4); drive_n(1'b1, 2);
      if (A !== 1'b1) bad++;
      chk("bounce_A_held", bad, 0);
      chk("bounce_no_fall", n_fall - f0, 0);
      A_raw = 1'b0;
      expect_edge("fall", 1'b0);
      chk("bounce_one_fall", n_fall - f0, 1);
      chk("bounce_glitch", glitch_cnt, 2);

      // Short high pulses are rejected and counted, saturating at 255
      r0 = n_rise;
      drive_n(1'b1, 10); drive_n(1'b0, 5);
      chk("pulse_A", A, 0);
      chk("pulse_glitch", glitch_cnt, 3);
      for (int i = 0; i < 300; i++) begin
         drive_n(1'b1, 10); drive_n(1'b0, 3);
         if (i == 99) chk("pulse_glitch_103", glitch_cnt, 103);
      end
      chk("pulse_glitch_sat", glitch_cnt, 255);
      chk("pulse_no_rise", n_rise - r0, 0);
      chk("pulse_A_end", A, 0);

      // Async reset mid WAIT_HI, then a full settle
      A_raw = 1'b1;
      repeat (10) @(negedge Clock);
      chk("mid_settling", settling, 1);
      #2 Reset = 1'b0;
      #1;
      chk("arst_A", A, 0);
      chk("arst_settling", settling, 0);
      chk("arst_glitch", glitch_cnt, 0);
      chk("arst_rise", A_rise, 0);
      @(negedge Clock);
      Reset = 1'b1;
      expect_edge("rel", 1'b1);

      // Random runs: width, exclusivity and strobe-integral checks
      hist = '1;
      lvl = 1'b1;
      prev_a = A;
      v = 1'b1;
      viol_w = 0; viol_both = 0; viol_int = 0; rr = 0; rf = 0;
      for (int run = 0; run < 60; run++) begin
         int len;
         v = ~v;
         len = int'($urandom_range(1, 30));
         for (int c = 0; c < len; c++) begin
            A_raw = v;
            @(negedge Clock);
            hist = {hist[30:0], v};
            if (A_rise && A_fall) viol_both++;
            if (A_rise) begin
               rr++;
               if (lvl !== 1'b0) viol_int++;
               lvl = 1'b1;
            end
            if (A_fall) begin
               rf++;
               if (lvl !== 1'b1) viol_int++;
               lvl = 1'b0;
            end
            if (A !== lvl) viol_int++;
            if (A && !prev_a && hist[17:2] != 16'hFFFF) viol_w++;
            if (!A && prev_a && hist[17:2] != 16'h0000) viol_w++;
            prev_a = A;
         end
      end
      chk("rand_width", viol_w, 0);
      chk("rand_excl", viol_both, 0);
      chk("rand_integral", viol_int, 0);
      chk("rand_rises_seen", (rr > 0), 1);
      chk("rand_falls_seen", (rf > 0), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
